pixel_window_buffer: RTL and testbench
======================================

PIXEL_WINDOW_BUFFER -- requirements
Module: pixel_window_buffer

Interface
REQ-001 Parameter MAX_COL, default 640, pixels per image row.
REQ-002 Parameter MAX_ROW, default 480, rows per frame.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sof  input  1  start of frame; qualifies the pixel on pix_in when pix_valid is high.
REQ-006 pix_in  input  8  grayscale pixel, raster order.
REQ-007 pix_valid  input  1  pix_in valid; accepted when pix_valid && in_ready.
REQ-008 in_ready  output  1  block can accept a pixel.
REQ-009 row  output  10  centre row of the emitted window.
REQ-010 col  output  10  centre column of the emitted window.
REQ-011 inputPixels  output  64  {top_left,top,top_right,mid_left,mid_right,bot_left,bot,bot_right}, 8 bits each, MSB first.
REQ-012 start  output  1  one-cycle pulse; row/col/inputPixels valid this cycle.
REQ-013 frame_done  output  1  one-cycle pulse after the last window of a frame.

Function
REQ-014 FSM states SHALL be IDLE, FILL, STREAM, FLUSH.
REQ-015 IDLE: pixels without sof dropped; accepted pixel with sof -> FILL, input index k=0.
REQ-016 FILL: accept pixels, no start; after index MAX_COL is accepted -> STREAM.
REQ-017 STREAM: acceptance of input index k SHALL produce start one clk later for centre index k-(MAX_COL+1), row/col = centre index / MAX_COL, mod MAX_COL.
REQ-018 After acceptance of index MAX_ROW*MAX_COL-1 -> FLUSH; in_ready low throughout FLUSH.
REQ-019 FLUSH: one start per clk for the remaining MAX_COL+1 centres, then frame_done pulse in the cycle after the last start, -> IDLE.
REQ-020 Output order strictly raster; exactly MAX_ROW*MAX_COL start pulses per complete frame.
REQ-021 Off-image taps (row-1<0, row+1>=MAX_ROW, col-1<0, col+1>=MAX_COL) SHALL be substituted per REQ-028/029; never data from an adjacent row or frame.
REQ-022 Gaps in pix_valid SHALL stall the pipeline without loss; start only follows an accepted pixel or a FLUSH cycle.
REQ-023 sof accepted in FILL/STREAM SHALL abort the current frame (no frame_done), restart at k=0 in FILL.
REQ-024 Counters SHALL wrap column MAX_COL-1 -> 0 with row increment; no arithmetic on pixel values.
REQ-025 Maximum throughput one pixel per clk, no bubbles in STREAM.

Reset
REQ-026 While reset is high: state IDLE, counters 0, start=0, frame_done=0, row=0, col=0, inputPixels=0, in_ready=0; in_ready=1 first cycle after reset deasserts.
REQ-027 Reset mid-frame SHALL discard all buffered pixels; no start pulse until a new sof frame reaches STREAM.

Configuration
REQ-028 With WINDOW_ZERO_PAD_EN defined, off-image taps SHALL be 8'h00.
REQ-029 Without WINDOW_ZERO_PAD_EN, off-image taps SHALL replicate the nearest in-image pixel (coordinate clamp).

Structure
REQ-030 Shared package pixel_pkg SHALL hold MAX_ROW/MAX_COL defaults, pixel width 8, window tap order/indices, FSM state encoding.
REQ-031 Sub-module line_buffer: MAX_COL-deep 8-bit delay line with enable; instantiated twice, plus 3x3 tap registers in the top.

Verification (bench with MAX_COL=4, MAX_ROW=3, pixel value = k+1)
REQ-032 Full frame, zero pad, continuous valid: first start 1 clk after k=5 accepted, row=0,col=0, inputPixels={0,0,0,0,2,0,5,6}; 12 starts total; frame_done once.
REQ-033 Same, clamp build: centre (0,0) inputPixels={1,1,2,1,2,5,5,6}; centre (2,3) inputPixels={7,8,8,11,12,11,12,12}.
REQ-034 pix_valid toggling 1/0 each clk: identical window sequence to REQ-032, starts spaced 2 clks; in_ready=0 for exactly 5 FLUSH cycles.
REQ-035 sof re-asserted at k=7: no frame_done, next start appears after new k=5, row=0,col=0.
REQ-036 reset pulsed during STREAM: start=0, in_ready=0 during reset; pixels without sof afterwards produce no start.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared definitions for the 3x3 pixel window buffer: geometry defaults, pixel width,
// window tap ordering inside the packed output word and the control FSM encoding.
package pixel_pkg;

  localparam int DEF_MAX_COL = 640;
  localparam int DEF_MAX_ROW = 480;
  localparam int PIX_W       = 8;
  localparam int WIN_TAPS    = 8;

  // Tap slot indices in the packed window; slot 7 occupies the most significant byte.
  localparam int TAP_TL = 7;
  localparam int TAP_T  = 6;
  localparam int TAP_TR = 5;
  localparam int TAP_ML = 4;
  localparam int TAP_MR = 3;
  localparam int TAP_BL = 2;
  localparam int TAP_B  = 1;
  localparam int TAP_BR = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_t;

endpackage

// File: rtl/line_buffer.sv
// One-row delay line: dout presents the pixel pushed DEPTH enables earlier.
// Storage is DEPTH-1 RAM words plus the registered read port, which supplies the last stage.
module line_buffer
  import pixel_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_COL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int WORDS = DEPTH - 1;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [PIX_W-1:0] mem [0:WORDS-1];
  logic [AW-1:0]    ptr_reg;
  logic [PIX_W-1:0] dout_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr_reg] <= din;
    end
  end

  // Read-before-write on the same address: the word leaving is the one written WORDS pushes ago.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg  <= '0;
      dout_reg <= '0;
    end else if (en) begin
      dout_reg <= mem[ptr_reg];
      ptr_reg  <= (ptr_reg == AW'(WORDS - 1)) ? '0 : ptr_reg + AW'(1);
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/pixel_window_buffer.sv
// Raster-order 3x3 neighbourhood generator with edge handling.
// Define WINDOW_ZERO_PAD_EN for zero-valued off-image taps; otherwise edge pixels are replicated.
module pixel_window_buffer
  import pixel_pkg::*;
#(
  parameter int MAX_COL = DEF_MAX_COL,
  parameter int MAX_ROW = DEF_MAX_ROW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sof,
  input  logic [PIX_W-1:0]          pix_in,
  input  logic                      pix_valid,
  output logic                      in_ready,
  output logic [9:0]                row,
  output logic [9:0]                col,
  output logic [WIN_TAPS*PIX_W-1:0] inputPixels,
  output logic                      start,
  output logic                      frame_done
);

  localparam int NPIX = MAX_COL * MAX_ROW;
  localparam int CW   = $clog2(NPIX + 1);

  state_t           state_reg, state_next;
  logic [CW-1:0]    in_cnt_reg, in_cnt_next;
  logic [9:0]       ctr_row_reg, ctr_row_next, ctr_col_reg, ctr_col_next;
  logic [9:0]       row_reg, row_next, col_reg, col_next;
  logic             start_reg, start_next;
  logic             done_pending_reg, done_pending_next, frame_done_reg;
  logic             accept, push, issue, centre_last;
  logic [PIX_W-1:0] lb_din, lb0_dout, lb1_dout;

  assign in_ready    = !reset && (state_reg != FLUSH);
  assign accept      = pix_valid && in_ready;
  assign centre_last = (ctr_row_reg == 10'(MAX_ROW - 1)) && (ctr_col_reg == 10'(MAX_COL - 1));
  assign lb_din      = (state_reg == FLUSH) ? '0 : pix_in;

  always_comb begin
    state_next        = state_reg;
    in_cnt_next       = in_cnt_reg;
    ctr_row_next      = ctr_row_reg;
    ctr_col_next      = ctr_col_reg;
    done_pending_next = 1'b0;
    push              = 1'b0;
    issue             = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept && sof) begin
          push         = 1'b1;
          state_next   = FILL;
          in_cnt_next  = CW'(1);
          ctr_row_next = '0;
          ctr_col_next = '0;
        end
      end
      FILL, STREAM: begin
        if (accept) begin
          push = 1'b1;
          if (sof) begin
            state_next   = FILL;
            in_cnt_next  = CW'(1);
            ctr_row_next = '0;
            ctr_col_next = '0;
          end else begin
            in_cnt_next = in_cnt_reg + CW'(1);
            if (state_reg == FILL) begin
              if (in_cnt_reg == CW'(MAX_COL)) state_next = STREAM;
            end else begin
              issue = 1'b1;
              if (in_cnt_reg == CW'(NPIX - 1)) state_next = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        // Dummy pushes drain the last MAX_COL+1 centres out of the window.
        push  = 1'b1;
        issue = 1'b1;
        if (centre_last) begin
          state_next        = IDLE;
          done_pending_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    start_next = issue;
    row_next   = row_reg;
    col_next   = col_reg;
    if (issue) begin
      row_next = ctr_row_reg;
      col_next = ctr_col_reg;
      if (ctr_col_reg == 10'(MAX_COL - 1)) begin
        ctr_col_next = '0;
        ctr_row_next = ctr_row_reg + 10'd1;
      end else begin
        ctr_col_next = ctr_col_reg + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      in_cnt_reg       <= '0;
      ctr_row_reg      <= '0;
      ctr_col_reg      <= '0;
      row_reg          <= '0;
      col_reg          <= '0;
      start_reg        <= 1'b0;
      done_pending_reg <= 1'b0;
      frame_done_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      in_cnt_reg       <= in_cnt_next;
      ctr_row_reg      <= ctr_row_next;
      ctr_col_reg      <= ctr_col_next;
      row_reg          <= row_next;
      col_reg          <= col_next;
      start_reg        <= start_next;
      done_pending_reg <= done_pending_next;
      frame_done_reg   <= done_pending_reg;
    end
  end

  line_buffer #(.DEPTH(MAX_COL)) u_lb0 (
    .clk   (clk),
    .reset (reset),
    .en    (push),
    .din   (lb_din),
    .dout  (lb0_dout)
  );

  line_buffer #(.DEPTH(MAX_COL)) u_lb1 (
    .clk   (clk),
    .reset (reset),
    .en    (push),
    .din   (lb0_dout),
    .dout  (lb1_dout)
  );

  logic [PIX_W-1:0] col_in  [3];
  logic [PIX_W-1:0] h_left  [3];
  logic [PIX_W-1:0] h_mid   [3];
  logic [PIX_W-1:0] h_right [3];
  logic             col_first, col_last, row_first, row_last;

  assign col_in[0] = lb1_dout;
  assign col_in[1] = lb0_dout;
  assign col_in[2] = lb_din;
  assign col_first = (col_reg == 10'd0);
  assign col_last  = (col_reg == 10'(MAX_COL - 1));
  assign row_first = (row_reg == 10'd0);
  assign row_last  = (row_reg == 10'(MAX_ROW - 1));

  // Row 0 = line above the centre, row 1 = centre line, row 2 = line below; each shifts left on push.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tap_row
      logic [PIX_W-1:0] left_reg, mid_reg, right_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          left_reg  <= '0;
          mid_reg   <= '0;
          right_reg <= '0;
        end else if (push) begin
          left_reg  <= mid_reg;
          mid_reg   <= right_reg;
          right_reg <= col_in[gi];
        end
      end

`ifdef WINDOW_ZERO_PAD_EN
      assign h_left[gi]  = col_first ? '0 : left_reg;
      assign h_right[gi] = col_last  ? '0 : right_reg;
`else
      assign h_left[gi]  = col_first ? mid_reg : left_reg;
      assign h_right[gi] = col_last  ? mid_reg : right_reg;
`endif
      assign h_mid[gi] = mid_reg;
    end
  endgenerate

  logic [PIX_W-1:0]          top_l, top_m, top_r, bot_l, bot_m, bot_r;
  logic [WIN_TAPS*PIX_W-1:0] window;

  always_comb begin
`ifdef WINDOW_ZERO_PAD_EN
    top_l = row_first ? '0 : h_left[0];
    top_m = row_first ? '0 : h_mid[0];
    top_r = row_first ? '0 : h_right[0];
    bot_l = row_last  ? '0 : h_left[2];
    bot_m = row_last  ? '0 : h_mid[2];
    bot_r = row_last  ? '0 : h_right[2];
`else
    // Vertical replication reuses the already column-clamped centre line, so corners clamp both ways.
    top_l = row_first ? h_left[1]  : h_left[0];
    top_m = row_first ? h_mid[1]   : h_mid[0];
    top_r = row_first ? h_right[1] : h_right[0];
    bot_l = row_last  ? h_left[1]  : h_left[2];
    bot_m = row_last  ? h_mid[1]   : h_mid[2];
    bot_r = row_last  ? h_right[1] : h_right[2];
`endif
    window = '0;
    window[TAP_TL*PIX_W +: PIX_W] = top_l;
    window[TAP_T *PIX_W +: PIX_W] = top_m;
    window[TAP_TR*PIX_W +: PIX_W] = top_r;
    window[TAP_ML*PIX_W +: PIX_W] = h_left[1];
    window[TAP_MR*PIX_W +: PIX_W] = h_right[1];
    window[TAP_BL*PIX_W +: PIX_W] = bot_l;
    window[TAP_B *PIX_W +: PIX_W] = bot_m;
    window[TAP_BR*PIX_W +: PIX_W] = bot_r;
  end

`ifdef WINDOW_ZERO_PAD_EN
  // The centre pixel itself is only needed as a replication source.
  logic unused_centre;
  assign unused_centre = ^h_mid[1];
`endif

  assign inputPixels = window;
  assign row         = row_reg;
  assign col         = col_reg;
  assign start       = start_reg;
  assign frame_done  = frame_done_reg;

endmodule

// File: tb/tb_pixel_window_buffer.sv
// Self-checking bench for pixel_window_buffer on a 4x3 image; build with or without
// WINDOW_ZERO_PAD_EN to check the matching edge policy.
module tb_pixel_window_buffer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset, sof, pix_valid, in_ready, start, frame_done;
  logic [7:0]  pix_in;
  logic [9:0]  row, col;
  logic [63:0] inputPixels;

  always #5 clk = ~clk;

  pixel_window_buffer #(.MAX_COL(W), .MAX_ROW(H)) dut (
    .clk         (clk),
    .reset       (reset),
    .sof         (sof),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .in_ready    (in_ready),
    .row         (row),
    .col         (col),
    .inputPixels (inputPixels),
    .start       (start),
    .frame_done  (frame_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int low_cnt = 0;
  logic [7:0]  img [N];
  logic [63:0] win_q [$];
  int          row_q [$];
  int          col_q [$];
  int          cyc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (start) begin
      win_q.push_back(inputPixels);
      row_q.push_back(int'(row));
      col_q.push_back(int'(col));
      cyc_q.push_back(cyc);
    end
    if (frame_done) done_cnt++;
    if (!in_ready && !reset) low_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Reference: image-coordinate lookup with the edge policy applied to out-of-image coordinates.
  function automatic int clampi(int v, int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [7:0] ref_tap(int r, int c);
    if (r < 0 || r >= H || c < 0 || c >= W) begin
`ifdef WINDOW_ZERO_PAD_EN
      return 8'h00;
`else
      return img[clampi(r, H - 1) * W + clampi(c, W - 1)];
`endif
    end
    return img[r * W + c];
  endfunction

  function automatic logic [63:0] ref_win(int r, int c);
    return {ref_tap(r-1, c-1), ref_tap(r-1, c), ref_tap(r-1, c+1),
            ref_tap(r,   c-1),                  ref_tap(r,   c+1),
            ref_tap(r+1, c-1), ref_tap(r+1, c), ref_tap(r+1, c+1)};
  endfunction

  task automatic clear_mon();
    @(posedge clk);
    win_q.delete();
    row_q.delete();
    col_q.delete();
    cyc_q.delete();
    done_cnt = 0;
    low_cnt  = 0;
  endtask

  // mode 0: continuous valid, 1: valid toggling, 2: random gaps
  task automatic drive_frame(input int mode, input int n, input bit with_sof, output int acc5);
    int guard;
    acc5 = -1;
    for (int k = 0; k < n; k++) begin
      if (mode == 1 && k > 0) begin
        @(negedge clk);
        pix_valid = 1'b0;
        sof = 1'b0;
      end
      if (mode == 2) begin
        while ($urandom_range(0, 1) == 0) begin
          @(negedge clk);
          pix_valid = 1'b0;
          sof = 1'b0;
        end
      end
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 50) begin
        pix_valid = 1'b0;
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL in_ready_wait: in_ready=%0b after 50 cycles, required 1", in_ready);
      end
      pix_valid = 1'b1;
      pix_in    = img[k];
      sof       = with_sof && (k == 0);
      if (k == 5) acc5 = cyc + 1;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    sof = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; sof = 1'b0; pix_valid = 1'b0; pix_in = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({start, frame_done, in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: start/frame_done/in_ready=%b, required 000", {start, frame_done, in_ready});
    end
    checks++;
    if ({row, col} !== 20'd0) begin
      errors++;
      $display("FAIL reset_rowcol: row=%0d col=%0d, required 0 0", row, col);
    end
    checks++;
    if (inputPixels !== 64'd0) begin
      errors++;
      $display("FAIL reset_pixels: inputPixels=%h, required 0", inputPixels);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_full_frame();
    int acc5;
    logic [63:0] exp00, exp23;
`ifdef WINDOW_ZERO_PAD_EN
    exp00 = 64'h0000_0000_0200_0506;
    exp23 = 64'h0708_000B_0000_0000;
`else
    exp00 = 64'h0101_0201_0205_0506;
    exp23 = 64'h0708_080B_0C0B_0C0C;
`endif
    for (int k = 0; k < N; k++) img[k] = 8'(k + 1);
    clear_mon();
    drive_frame(0, N, 1'b1, acc5);
    wait_done(1);
    checks++;
    if (win_q.size() != N) begin
      errors++;
      $display("FAIL full_count: starts=%0d, required %0d", win_q.size(), N);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL full_done: frame_done pulses=%0d, required 1", done_cnt);
    end
    if (win_q.size() == N) begin
      checks++;
      if (cyc_q[0] != acc5 || row_q[0] != 0 || col_q[0] != 0) begin
        errors++;
        $display("FAIL full_first: cycle=%0d row=%0d col=%0d, required cycle=%0d row=0 col=0",
                 cyc_q[0], row_q[0], col_q[0], acc5);
      end
      checks++;
      if (win_q[0] !== exp00) begin
        errors++;
        $display("FAIL full_win00: got %h, required %h", win_q[0], exp00);
      end
      checks++;
      if (win_q[N-1] !== exp23) begin
        errors++;
        $display("FAIL full_win23: got %h, required %h", win_q[N-1], exp23);
      end
    end
    for (int i = 0; i < win_q.size() && i < N; i++) begin
      checks++;
      if (win_q[i] !== ref_win(i / W, i % W) || row_q[i] != i / W || col_q[i] != i % W) begin
        errors++;
        $display("FAIL full_window[%0d]: got r%0d c%0d %h, required r%0d c%0d %h",
                 i, row_q[i], col_q[i], win_q[i], i / W, i % W, ref_win(i / W, i % W));
      end
    end
    $display("test_full_frame done: %0d windows", win_q.size());
  endtask

  task automatic test_toggle_valid();
    int acc5;
    for (int k = 0; k < N; k++) img[k] = 8'(k + 1);
    clear_mon();
    drive_frame(1, N, 1'b1, acc5);
    wait_done(1);
    checks++;
    if (win_q.size() != N || done_cnt != 1) begin
      errors++;
      $display("FAIL toggle_count: starts=%0d done=%0d, required %0d 1", win_q.size(), done_cnt, N);
    end
    checks++;
    if (low_cnt != W + 1) begin
      errors++;
      $display("FAIL toggle_flush_ready: in_ready low cycles=%0d, required %0d", low_cnt, W + 1);
    end
    for (int i = 0; i + 1 < N - W - 1 && i + 1 < win_q.size(); i++) begin
      checks++;
      if (cyc_q[i+1] - cyc_q[i] != 2) begin
        errors++;
        $display("FAIL toggle_spacing[%0d]: gap=%0d, required 2", i, cyc_q[i+1] - cyc_q[i]);
      end
    end
    for (int i = 0; i < win_q.size() && i < N; i++) begin
      checks++;
      if (win_q[i] !== ref_win(i / W, i % W) || row_q[i] != i / W || col_q[i] != i % W) begin
        errors++;
        $display("FAIL toggle_window[%0d]: got r%0d c%0d %h, required r%0d c%0d %h",
                 i, row_q[i], col_q[i], win_q[i], i / W, i % W, ref_win(i / W, i % W));
      end
    end
    $display("test_toggle_valid done: %0d windows", win_q.size());
  endtask

  task automatic test_random_frames();
    int acc5;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N; k++) img[k] = 8'($urandom_range(0, 255));
      clear_mon();
      drive_frame(2, N, 1'b1, acc5);
      wait_done(1);
      checks++;
      if (win_q.size() != N || done_cnt != 1) begin
        errors++;
        $display("FAIL random_count[%0d]: starts=%0d done=%0d, required %0d 1", f, win_q.size(), done_cnt, N);
      end
      for (int i = 0; i < win_q.size() && i < N; i++) begin
        checks++;
        if (win_q[i] !== ref_win(i / W, i % W) || row_q[i] != i / W || col_q[i] != i % W) begin
          errors++;
          $display("FAIL random_window[%0d.%0d]: got r%0d c%0d %h, required r%0d c%0d %h",
                   f, i, row_q[i], col_q[i], win_q[i], i / W, i % W, ref_win(i / W, i % W));
        end
      end
      $display("test_random_frames frame %0d done: %0d windows", f, win_q.size());
    end
  endtask

  task automatic test_sof_abort();
    int acc5;
    for (int k = 0; k < N; k++) img[k] = 8'($urandom_range(0, 255));
    clear_mon();
    drive_frame(0, 7, 1'b1, acc5);
    for (int k = 0; k < N; k++) img[k] = 8'($urandom_range(0, 255));
    drive_frame(0, N, 1'b1, acc5);
    wait_done(1);
    checks++;
    if (done_cnt != 1 || win_q.size() != N + 2) begin
      errors++;
      $display("FAIL abort_count: done=%0d starts=%0d, required 1 %0d", done_cnt, win_q.size(), N + 2);
    end
    if (win_q.size() == N + 2) begin
      checks++;
      if (cyc_q[2] != acc5 || row_q[2] != 0 || col_q[2] != 0) begin
        errors++;
        $display("FAIL abort_restart: cycle=%0d row=%0d col=%0d, required cycle=%0d row=0 col=0",
                 cyc_q[2], row_q[2], col_q[2], acc5);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (win_q[i+2] !== ref_win(i / W, i % W) || row_q[i+2] != i / W || col_q[i+2] != i % W) begin
          errors++;
          $display("FAIL abort_window[%0d]: got r%0d c%0d %h, required r%0d c%0d %h",
                   i, row_q[i+2], col_q[i+2], win_q[i+2], i / W, i % W, ref_win(i / W, i % W));
        end
      end
    end
    $display("test_sof_abort done: %0d windows", win_q.size());
  endtask

  task automatic test_reset_midframe();
    int acc5;
    for (int k = 0; k < N; k++) img[k] = 8'($urandom_range(0, 255));
    drive_frame(0, 9, 1'b1, acc5);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (start !== 1'b0 || in_ready !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: start=%b in_ready=%b frame_done=%b, required 0 0 0",
               start, in_ready, frame_done);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    drive_frame(0, N, 1'b0, acc5);
    repeat (20) @(negedge clk);
    checks++;
    if (win_q.size() != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL midreset_nosof: starts=%0d done=%0d, required 0 0", win_q.size(), done_cnt);
    end
    for (int k = 0; k < N; k++) img[k] = 8'($urandom_range(0, 255));
    clear_mon();
    drive_frame(0, N, 1'b1, acc5);
    wait_done(1);
    checks++;
    if (win_q.size() != N || done_cnt != 1) begin
      errors++;
      $display("FAIL midreset_frame: starts=%0d done=%0d, required %0d 1", win_q.size(), done_cnt, N);
    end
    for (int i = 0; i < win_q.size() && i < N; i++) begin
      checks++;
      if (win_q[i] !== ref_win(i / W, i % W) || row_q[i] != i / W || col_q[i] != i % W) begin
        errors++;
        $display("FAIL midreset_window[%0d]: got r%0d c%0d %h, required r%0d c%0d %h",
                 i, row_q[i], col_q[i], win_q[i], i / W, i % W, ref_win(i / W, i % W));
      end
    end
    $display("test_reset_midframe done: %0d windows", win_q.size());
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_toggle_valid();
    test_random_frames();
    test_sof_abort();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
